// File: rtl/pc_ir_stage_if.sv
// -----------------------------------------------------------------------------
// pc_ir_stage_if
//   Signal bundle between the multi-cycle MIPS control/datapath side and the
//   PC/IR state-holding stage.
//
//   master : the surrounding datapath and control FSM. It drives the control
//            strobes, ALU results, memory read data and register-file reads,
//            and it consumes the stage outputs.
//   slave  : pc_ir_stage. It consumes the strobes and data and drives the PC,
//            memory address, IR, decoded fields, latched operands, fetch
//            counter and error flag.
//
//   Parameter CNT_W : width of fetch_count. It must match the width used by
//                     the pc_ir_stage instance.
// -----------------------------------------------------------------------------
interface pc_ir_stage_if #(
  parameter int CNT_W = 32
);
  // Control strobes from the control FSM.
  logic              pc_write;
  logic              branch;
  logic [1:0]        pc_src;
  logic              ir_write;
  logic              IorD;

  // Datapath inputs. All are combinational in the current cycle.
  logic              alu_zero;
  logic [31:0]       alu_result;
  logic [31:0]       mem_rdata;
  logic [31:0]       rd1;
  logic [31:0]       rd2;

  // Stage outputs.
  logic [31:0]       pc;
  logic [31:0]       mem_addr;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [31:0]       imm_sext;
  logic [31:0]       imm_sh2;
  logic [31:0]       jump_target;
  logic [31:0]       mdr;
  logic [31:0]       reg_a;
  logic [31:0]       reg_b;
  logic [31:0]       alu_out;
  logic [CNT_W-1:0]  fetch_count;
  logic              misalign_err;

  modport master (
    output pc_write, branch, pc_src, ir_write, IorD,
           alu_zero, alu_result, mem_rdata, rd1, rd2,
    input  pc, mem_addr, instr, opcode, funct, rs, rt, rd,
           imm_sext, imm_sh2, jump_target, mdr, reg_a, reg_b, alu_out,
           fetch_count, misalign_err
  );

  modport slave (
    input  pc_write, branch, pc_src, ir_write, IorD,
           alu_zero, alu_result, mem_rdata, rd1, rd2,
    output pc, mem_addr, instr, opcode, funct, rs, rt, rd,
           imm_sext, imm_sh2, jump_target, mdr, reg_a, reg_b, alu_out,
           fetch_count, misalign_err
  );
endinterface

// File: rtl/pc_ir_stage.sv
// -----------------------------------------------------------------------------
// pc_ir_stage
//   Front-end state-holding stage of the multi-cycle MIPS datapath. It holds
//   the PC, the instruction register and the inter-cycle registers MDR, A, B
//   and ALUOut. It has no sequencing of its own: every load is commanded by
//   the control FSM's strobes, and the stage never stalls.
//
// Parameters
//   RESET_PC : PC value loaded on reset.
//   CNT_W    : width of the retired-fetch counter.
//
// Ports
//   clk   : clock. All registers load on the rising edge.
//   rstn  : asynchronous active-low reset.
//   bus   : pc_ir_stage_if.slave
//           inputs  : pc_write, branch, pc_src, ir_write, IorD, alu_zero,
//                     alu_result, mem_rdata, rd1, rd2
//           outputs : pc, mem_addr, instr, opcode, funct, rs, rt, rd,
//                     imm_sext, imm_sh2, jump_target, mdr, reg_a, reg_b,
//                     alu_out, fetch_count, misalign_err
// -----------------------------------------------------------------------------
module pc_ir_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rstn,
  pc_ir_stage_if.slave   bus
);

  // Next-PC source encoding.
  typedef enum logic [1:0] {
    SRC_ALU_RESULT = 2'b00,  // PC+4 computed during FETCH
    SRC_ALU_OUT    = 2'b01,  // branch target latched during DECODE
    SRC_JUMP       = 2'b10,  // pseudo-direct jump target
    SRC_RESERVED   = 2'b11   // falls back to alu_result
  } pc_src_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_mdr;
  logic [31:0]      r_reg_a;
  logic [31:0]      r_reg_b;
  logic [31:0]      r_alu_out;
  logic [CNT_W-1:0] r_fetch_count;
  logic             r_misalign_err;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic             w_pc_en;
  logic [31:0]      w_pc_next;
  logic [31:0]      w_imm_sext;
  logic [31:0]      w_jump_target;
  pc_src_e          w_pc_src;

  assign w_pc_src = pc_src_e'(bus.pc_src);

  // A branch loads the PC only when the ALU compare is zero. If pc_write and
  // a taken branch occur together, the PC still loads only once.
  assign w_pc_en = bus.pc_write | (bus.branch & bus.alu_zero);

  // The jump target uses the registered PC. After FETCH, that PC already
  // holds PC+4, so this gives the MIPS j/jal region semantics.
  assign w_jump_target = {r_pc[31:28], r_instr[25:0], 2'b00};

  assign w_imm_sext = {{16{r_instr[15]}}, r_instr[15:0]};

  // NOTE: always_comb assigns a default before the case so no path leaves
  // w_pc_next unassigned; a missing default here would infer a latch.
  always_comb begin
    w_pc_next = bus.alu_result;
    unique case (w_pc_src)
      SRC_ALU_RESULT: w_pc_next = bus.alu_result;
      SRC_ALU_OUT:    w_pc_next = r_alu_out;
      SRC_JUMP:       w_pc_next = w_jump_target;
      SRC_RESERVED:   w_pc_next = bus.alu_result;
      default:        w_pc_next = bus.alu_result;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. In FETCH, the IR
  // captures mem_rdata addressed by the old PC while the PC moves to PC+4 on
  // the same edge. Blocking assignments would make that ordering depend on
  // statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc           <= RESET_PC;
      r_instr        <= '0;
      r_mdr          <= '0;
      r_reg_a        <= '0;
      r_reg_b        <= '0;
      r_alu_out      <= '0;
      r_fetch_count  <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      // These inter-cycle registers load on every edge. Control selects which
      // cycle's value it consumes.
      r_mdr     <= bus.mem_rdata;
      r_reg_a   <= bus.rd1;
      r_reg_b   <= bus.rd2;
      r_alu_out <= bus.alu_result;

      // A misaligned target is refused: the PC keeps its value, and the error
      // flag latches until reset.
      if (w_pc_en) begin
        if (w_pc_next[1:0] == 2'b00) begin
          r_pc <= w_pc_next;
        end else begin
          r_misalign_err <= 1'b1;
        end
      end

      if (bus.ir_write) begin
        r_instr       <= bus.mem_rdata;
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc           = r_pc;
  assign bus.mem_addr     = bus.IorD ? r_alu_out : r_pc;
  assign bus.instr        = r_instr;
  assign bus.opcode       = r_instr[31:26];
  assign bus.rs           = r_instr[25:21];
  assign bus.rt           = r_instr[20:16];
  assign bus.rd           = r_instr[15:11];
  assign bus.funct        = r_instr[5:0];
  assign bus.imm_sext     = w_imm_sext;
  assign bus.imm_sh2      = {w_imm_sext[29:0], 2'b00};
  assign bus.jump_target  = w_jump_target;
  assign bus.mdr          = r_mdr;
  assign bus.reg_a        = r_reg_a;
  assign bus.reg_b        = r_reg_b;
  assign bus.alu_out      = r_alu_out;
  assign bus.fetch_count  = r_fetch_count;
  assign bus.misalign_err = r_misalign_err;

endmodule
